vsram_stream_ctrl: RTL

Sequencer that owns the V-vector SRAM FIFO for one attention job. It clears the FIFO, loads exactly `ROWS` V vectors from the memory controller, then replays the full V set to the backend PEs once per query tile, for `num_passes` passes. It sits between the memory controller, the V FIFO and the backend PE array, and reports per-row, per-pass and per-job progress to the top-level scheduler.

---
 rtl/vsram_stream_ctrl_pkg.sv | 19 +
 rtl/vsram_stream_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/vsram_stream_ctrl_pkg.sv
// Shared definitions for the V-vector SRAM stream sequencer.
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 8
`endif

package vsram_stream_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FILL,
        ST_STREAM,
        ST_DONE
    } vstream_state_t;

    localparam int ROW_IDX_W = $clog2(`MAX_SEQ_LENGTH);
    localparam int PASS_W_DEFAULT = 8;

endpackage

// File: rtl/vsram_stream_ctrl.sv
// Clears the V FIFO, loads ROWS vectors, then replays them to the PEs
// once per pass and reports row, pass and job progress.
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 8
`endif

module vsram_stream_ctrl
    import vsram_stream_ctrl_pkg::*;
#(
    parameter int ROWS   = `MAX_SEQ_LENGTH,
    parameter int PASS_W = PASS_W_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PASS_W-1:0]        num_passes,
    input  logic                     mem_v_valid,
    output logic                     mem_v_ready,
    output logic                     vsram_clear,
    output logic                     vsram_write_enable,
    input  logic                     vsram_ready,
    input  logic                     vsram_read_data_valid,
    output logic                     vsram_read_enable,
    input  logic                     pe_ready,
    output logic                     v_row_valid,
    output logic [$clog2(ROWS)-1:0]  row_idx,
    output logic                     last_row,
    output logic [PASS_W-1:0]        pass_idx,
    output logic                     pass_done,
    output logic                     busy,
    output logic                     done
);

    localparam int RW = $clog2(ROWS);
    localparam logic [RW:0] WR_LAST = (RW+1)'(ROWS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    vstream_state_t state;
    vstream_state_t state_next;

    logic [RW:0]       wr_cnt;
    logic [RW-1:0]     row_cnt;
    logic [PASS_W-1:0] pass_cnt;
    logic [PASS_W-1:0] pass_max;

    assign row_idx  = row_cnt;
    assign pass_idx = pass_cnt;
    assign last_row = (row_cnt == ROW_LAST);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    always_comb begin
        state_next         = state;
        mem_v_ready        = 1'b0;
        vsram_write_enable = 1'b0;
        vsram_clear        = 1'b0;
        v_row_valid        = 1'b0;
        vsram_read_enable  = 1'b0;
        pass_done          = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                vsram_clear = 1'b1;
                state_next  = ST_FILL;
            end
            ST_FILL: begin
                mem_v_ready        = vsram_ready;
                vsram_write_enable = mem_v_valid & vsram_ready;
                if (vsram_write_enable && wr_cnt == WR_LAST)
                    state_next = ST_STREAM;
            end
            ST_STREAM: begin
                v_row_valid       = vsram_read_data_valid;
                vsram_read_enable = pe_ready & vsram_read_data_valid;
                if (vsram_read_enable && last_row) begin
                    pass_done = 1'b1;
                    if (pass_cnt == pass_max - PASS_W'(1))
                        state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            wr_cnt   <= '0;
            row_cnt  <= '0;
            pass_cnt <= '0;
            pass_max <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && start) begin
                wr_cnt   <= '0;
                row_cnt  <= '0;
                pass_cnt <= '0;
                // a zero pass request still replays the set once
                pass_max <= (num_passes == '0) ? PASS_W'(1) : num_passes;
            end
            if (vsram_write_enable)
                wr_cnt <= wr_cnt + (RW+1)'(1);
            if (vsram_read_enable) begin
                row_cnt <= row_cnt + RW'(1);
                if (last_row)
                    pass_cnt <= pass_cnt + PASS_W'(1);
            end
        end
    end

endmodule
